// File: rtl/evict_buffer_pkg.sv
// Shared LC-3b memory types plus evict-buffer line-address and FSM encodings.
// Optional read forwarding from buffered lines is enabled by defining EVICT_BUFFER_FWD_EN.
package evict_buffer_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_data;
    typedef logic [11:0]  lc3b_line_addr;

    localparam int EVB_LINE_OFFSET = 4;

    // Controller states, also visible on the fsm_state debug port
    localparam logic [1:0] EVB_IDLE  = 2'd0;
    localparam logic [1:0] EVB_DRAIN = 2'd1;
    localparam logic [1:0] EVB_READ  = 2'd2;
    localparam logic [1:0] EVB_RESP  = 2'd3;

    function automatic lc3b_line_addr line_of(input lc3b_word addr);
        return addr[15:EVB_LINE_OFFSET];
    endfunction

endpackage

// File: rtl/evict_buffer_fifo.sv
// Circular store of evicted lines {line address, data} with head/tail/count.
// With EVICT_BUFFER_FWD_EN defined it also finds the newest entry matching a lookup line.
module evict_buffer_fifo
    import evict_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  lc3b_line_addr                push_addr,
    input  lc3b_data                     push_data,
    input  logic                         pop,
`ifdef EVICT_BUFFER_FWD_EN
    input  lc3b_line_addr                lookup_addr,
    output logic                         hit,
    output lc3b_data                     hit_data,
`endif
    output lc3b_line_addr                head_addr,
    output lc3b_data                     head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    lc3b_line_addr  addr_mem [DEPTH];
    lc3b_data       data_mem [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            // Simultaneous push and pop leaves the occupancy unchanged
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Line storage carries no reset; validity is defined by head and count
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
        end
    end

    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);

`ifdef EVICT_BUFFER_FWD_EN
    logic [PW-1:0] scan_idx;

    // Walk oldest to newest so the last match seen is the newest copy of the line
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = PW'((int'(head) + i) % DEPTH);
            if ((i < int'(count)) && (addr_mem[scan_idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_mem[scan_idx];
            end
        end
    end
`endif

endmodule

// File: rtl/evict_buffer.sv
// Write-back evict buffer between an LC-3b cache and physical memory.
// Define EVICT_BUFFER_FWD_EN to serve reads from buffered lines instead of draining first.
module evict_buffer
    import evict_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  lc3b_word                     cache_address,
    input  lc3b_data                     cache_wdata,
    output lc3b_data                     cache_rdata,
    input  logic                         cache_read,
    input  logic                         cache_write,
    output logic                         cache_resp,
    output lc3b_word                     pmem_address,
    output lc3b_data                     pmem_wdata,
    output logic                         pmem_read,
    output logic                         pmem_write,
    input  lc3b_data                     pmem_rdata,
    input  logic                         pmem_resp,
    output logic [1:0]                   fsm_state,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    // Handshake: cache_read/cache_write are held until the one-cycle cache_resp;
    // pmem_read/pmem_write with pmem_address/pmem_wdata are held until pmem_resp.

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic          wr_resp;
    logic          push;
    logic          pop;
    logic          read_req;
    logic          full;
    logic          empty;
    lc3b_line_addr head_addr;
    lc3b_data      head_data;
`ifdef EVICT_BUFFER_FWD_EN
    logic          hit;
    lc3b_data      hit_data;
`endif

    // A write wins over a simultaneous (illegal) read; wr_resp blocks re-enqueue of the held request
    assign read_req = cache_read && !cache_write;
    assign push     = cache_write && !full && !wr_resp;
    assign pop      = (state == EVB_DRAIN) && pmem_resp;

    evict_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_addr   (line_of(cache_address)),
        .push_data   (cache_wdata),
        .pop         (pop),
`ifdef EVICT_BUFFER_FWD_EN
        .lookup_addr (line_of(cache_address)),
        .hit         (hit),
        .hit_data    (hit_data),
`endif
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    always_comb begin
        next_state = state;
        case (state)
            EVB_IDLE: begin
`ifdef EVICT_BUFFER_FWD_EN
                if (read_req && hit)
                    next_state = EVB_RESP;
                else if (read_req)
                    next_state = EVB_READ;
`else
                if (read_req && empty)
                    next_state = EVB_READ;
`endif
                else if (!empty)
                    next_state = EVB_DRAIN;
            end
            EVB_DRAIN: if (pmem_resp) next_state = EVB_IDLE;
            EVB_READ:  if (pmem_resp) next_state = EVB_RESP;
            default:   next_state = EVB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EVB_IDLE;
            wr_resp <= 1'b0;
        end else begin
            state   <= next_state;
            wr_resp <= push;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cache_rdata <= '0;
        else if ((state == EVB_READ) && pmem_resp)
            cache_rdata <= pmem_rdata;
`ifdef EVICT_BUFFER_FWD_EN
        else if ((state == EVB_IDLE) && read_req && hit)
            cache_rdata <= hit_data;
`endif
    end

    assign pmem_read    = (state == EVB_READ);
    assign pmem_write   = (state == EVB_DRAIN);
    assign pmem_address = (state == EVB_DRAIN) ? {head_addr, {EVB_LINE_OFFSET{1'b0}}} : cache_address;
    assign pmem_wdata   = head_data;
    assign cache_resp   = wr_resp || (state == EVB_RESP);
    assign fsm_state    = state;

endmodule

// File: tb/tb_evict_buffer.sv
// Self-checking bench for evict_buffer: random-latency memory model, coherent-view reference
// model (buffered lines plus memory image) and a FIFO drain scoreboard.
module tb_evict_buffer;
    import evict_buffer_pkg::*;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int BUDGET = 400;

    logic           clk;
    logic           rst_n;
    lc3b_word       cache_address;
    lc3b_data       cache_wdata;
    lc3b_data       cache_rdata;
    logic           cache_read;
    logic           cache_write;
    logic           cache_resp;
    lc3b_word       pmem_address;
    lc3b_data       pmem_wdata;
    logic           pmem_read;
    logic           pmem_write;
    lc3b_data       pmem_rdata;
    logic           pmem_resp;
    logic [1:0]     fsm_state;
    logic [CW-1:0]  count;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: lines written but not yet drained, in write order, plus the memory image
    logic [139:0]   exp_q[$];
    lc3b_data       mem_model [lc3b_line_addr];
    logic [16:0]    txn_log[$];
    int             mem_delay   = -1;
    int             drains_done = 0;
    int             reads_done  = 0;
    int             rst_epoch   = 0;

    evict_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cache_address (cache_address),
        .cache_wdata   (cache_wdata),
        .cache_rdata   (cache_rdata),
        .cache_read    (cache_read),
        .cache_write   (cache_write),
        .cache_resp    (cache_resp),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .fsm_state     (fsm_state),
        .count         (count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model helpers ----------------
    function automatic lc3b_data background(input lc3b_line_addr a);
        return {8{a, 4'hC}};
    endfunction

    function automatic lc3b_data coherent(input lc3b_line_addr a);
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i][139:128] == a) return exp_q[i][127:0];
        if (mem_model.exists(a)) return mem_model[a];
        return background(a);
    endfunction

    function automatic bit buffered(input lc3b_line_addr a);
        foreach (exp_q[i])
            if (exp_q[i][139:128] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic lc3b_data rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- physical memory responder + drain scoreboard ----------------
    initial begin : responder
        lc3b_word a;
        lc3b_data wd;
        logic     is_wr;
        int       ep;
        int       d;
        logic [139:0] exp_entry;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (rst_n && (pmem_read || pmem_write)) begin
                a = pmem_address; wd = pmem_wdata; is_wr = pmem_write; ep = rst_epoch;
                txn_log.push_back({is_wr, a});
                vectors++;
                if (pmem_read && pmem_write) begin
                    miscompares++;
                    $display("FAIL pmem_excl: read=%0b write=%0b, required not both", pmem_read, pmem_write);
                end
                if (!is_wr) begin
                    vectors++;
`ifdef EVICT_BUFFER_FWD_EN
                    if (buffered(line_of(a))) begin
                        miscompares++;
                        $display("FAIL read_hit_to_pmem: addr=%h is buffered, required forwarding", a);
                    end
`else
                    if (exp_q.size() != 0) begin
                        miscompares++;
                        $display("FAIL read_before_drain: addr=%h with %0d lines buffered, required 0", a, exp_q.size());
                    end
`endif
                end
                d = (mem_delay >= 0) ? mem_delay : int'($urandom_range(0, 3));
                for (int k = 0; k < d; k++) begin
                    @(negedge clk);
                    if (ep == rst_epoch) begin
                        vectors++;
                        if (pmem_address !== a || pmem_write !== is_wr || pmem_read !== !is_wr ||
                            (is_wr && pmem_wdata !== wd)) begin
                            miscompares++;
                            $display("FAIL pmem_stable: addr=%h rd=%0b wr=%0b, required addr=%h wr=%0b held",
                                     pmem_address, pmem_read, pmem_write, a, is_wr);
                        end
                    end
                end
                if (ep == rst_epoch) begin
                    if (is_wr) begin
                        vectors++;
                        exp_entry = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                        if ({line_of(a), wd} !== exp_entry || a[3:0] !== 4'h0) begin
                            miscompares++;
                            $display("FAIL drain_order: got addr=%h data=%h, required addr=%h0 data=%h",
                                     a, wd, exp_entry[139:128], exp_entry[127:0]);
                        end
                        mem_model[line_of(a)] = wd;
                        drains_done++;
                    end else begin
                        pmem_rdata = mem_model.exists(line_of(a)) ? mem_model[line_of(a)] : background(line_of(a));
                        reads_done++;
                    end
                end
                pmem_resp = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_resp(input string name, output int lat, output lc3b_data data);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cache_resp && n < BUDGET);
        vectors++;
        if (!cache_resp) begin
            miscompares++;
            $display("FAIL %s_timeout: no cache_resp within %0d cycles, required a response", name, BUDGET);
        end
        lat  = n - 1;
        data = cache_rdata;
        @(posedge clk); #1;
    endtask

    task automatic do_write(input lc3b_word a, input lc3b_data d, output int lat);
        lc3b_data unused;
        cache_address = a; cache_wdata = d; cache_write = 1'b1;
        exp_q.push_back({line_of(a), d});
        wait_resp("write", lat, unused);
        cache_write = 1'b0;
    endtask

    task automatic do_read(input lc3b_word a, output lc3b_data data, output int lat);
        cache_address = a; cache_read = 1'b1;
        wait_resp("read", lat, data);
        cache_read = 1'b0;
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(count == '0 && fsm_state == EVB_IDLE && exp_q.size() == 0) && n < BUDGET);
        vectors++;
        if (exp_q.size() != 0 || count != '0) begin
            miscompares++;
            $display("FAIL drain_timeout: count=%0d pending=%0d, required 0", count, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; cache_read = 1'b0; cache_write = 1'b0;
        cache_address = '0; cache_wdata = '0;
        repeat (3) @(negedge clk);
        vectors += 6;
        if (cache_resp !== 1'b0)  begin miscompares++; $display("FAIL rst_cache_resp: got %b, required 0", cache_resp); end
        if (pmem_read !== 1'b0)   begin miscompares++; $display("FAIL rst_pmem_read: got %b, required 0", pmem_read); end
        if (pmem_write !== 1'b0)  begin miscompares++; $display("FAIL rst_pmem_write: got %b, required 0", pmem_write); end
        if (cache_rdata !== '0)   begin miscompares++; $display("FAIL rst_cache_rdata: got %h, required 0", cache_rdata); end
        if (count !== '0)         begin miscompares++; $display("FAIL rst_count: got %0d, required 0", count); end
        if (fsm_state !== EVB_IDLE) begin miscompares++; $display("FAIL rst_state: got %0d, required %0d", fsm_state, EVB_IDLE); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        int lat;
        lc3b_data a_data;
        a_data = rand_data();
        mem_delay = 2;
        txn_log.delete();
        do_write(16'h1230, a_data, lat);
        vectors++;
        if (lat != 1) begin miscompares++; $display("FAIL single_write_lat: got %0d, required 1", lat); end
        wait_drained();
        vectors += 3;
        if (count !== '0) begin miscompares++; $display("FAIL single_count: got %0d, required 0", count); end
        if (!mem_model.exists(12'h123) || mem_model[12'h123] !== a_data) begin
            miscompares++; $display("FAIL single_mem: line 123 not written with %h", a_data);
        end
        if (txn_log.size() != 1 || txn_log[0] !== {1'b1, 16'h1230}) begin
            miscompares++; $display("FAIL single_txn: got %0d txns first=%h, required 1 write of 1230", txn_log.size(), txn_log[0]);
        end
    endtask

    task automatic test_full_stall();
        int lat;
        int base;
        mem_delay = 5;
        txn_log.delete();
        do_write(16'h1000, rand_data(), lat);
        vectors++;
        if (lat != 1) begin miscompares++; $display("FAIL stall_w1_lat: got %0d, required 1", lat); end
        do_write(16'h2000, rand_data(), lat);
        vectors++;
        if (lat != 1) begin miscompares++; $display("FAIL stall_w2_lat: got %0d, required 1", lat); end
        base = drains_done;
        do_write(16'h3000, rand_data(), lat);
        vectors += 2;
        if (drains_done <= base) begin miscompares++; $display("FAIL stall_early_resp: drains=%0d, required > %0d", drains_done, base); end
        if (lat < 2) begin miscompares++; $display("FAIL stall_w3_lat: got %0d, required >= 2", lat); end
        wait_drained();
        vectors++;
        if (txn_log.size() != 3 || txn_log[0] !== {1'b1, 16'h1000} || txn_log[1] !== {1'b1, 16'h2000} ||
            txn_log[2] !== {1'b1, 16'h3000}) begin
            miscompares++; $display("FAIL stall_order: got %0d txns, required writes 1000,2000,3000", txn_log.size());
        end
    endtask

    task automatic test_forward();
        int lat;
        int rd0;
        lc3b_data b_data, c_data, got;
        b_data = rand_data(); c_data = rand_data();
        mem_delay = 6;
        do_write(16'h4450, b_data, lat);
        do_write(16'h4450, c_data, lat);
        rd0 = reads_done;
        do_read(16'h4450, got, lat);
        vectors += 2;
        if (got !== c_data) begin miscompares++; $display("FAIL fwd_data: got %h, required %h", got, c_data); end
`ifdef EVICT_BUFFER_FWD_EN
        if (reads_done != rd0) begin miscompares++; $display("FAIL fwd_no_pmem: reads=%0d, required %0d", reads_done, rd0); end
`else
        if (reads_done != rd0 + 1) begin miscompares++; $display("FAIL fwd_pmem_read: reads=%0d, required %0d", reads_done, rd0 + 1); end
`endif
        wait_drained();
    endtask

    task automatic test_read_priority();
        int lat;
        lc3b_data got, exp;
        mem_delay = 4;
        txn_log.delete();
        do_write(16'h5000, rand_data(), lat);
        do_write(16'h5010, rand_data(), lat);
        exp = coherent(12'h600);
        do_read(16'h6000, got, lat);
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL prio_data: got %h, required %h", got, exp); end
        wait_drained();
        vectors++;
`ifdef EVICT_BUFFER_FWD_EN
        if (txn_log.size() != 3 || txn_log[1] !== {1'b0, 16'h6000} || txn_log[2] !== {1'b1, 16'h5010}) begin
            miscompares++; $display("FAIL prio_order: got %0d txns second=%h, required read 6000 before write 5010", txn_log.size(), txn_log[1]);
        end
`else
        if (txn_log.size() != 3 || txn_log[1] !== {1'b1, 16'h5010} || txn_log[2] !== {1'b0, 16'h6000}) begin
            miscompares++; $display("FAIL prio_order: got %0d txns second=%h, required write 5010 before read 6000", txn_log.size(), txn_log[1]);
        end
`endif
    endtask

    task automatic test_read_write_together();
        int lat;
        int rd0;
        lc3b_data e_data, got, unused;
        e_data = rand_data();
        mem_delay = 1;
        rd0 = reads_done;
        cache_address = 16'h8880; cache_wdata = e_data;
        cache_write = 1'b1; cache_read = 1'b1;
        exp_q.push_back({12'h888, e_data});
        wait_resp("both", lat, unused);
        cache_write = 1'b0;
        vectors += 2;
        if (lat != 1) begin miscompares++; $display("FAIL both_write_lat: got %0d, required 1", lat); end
        if (reads_done != rd0) begin miscompares++; $display("FAIL both_read_ignored: reads=%0d, required %0d", reads_done, rd0); end
        wait_resp("both_read", lat, got);
        cache_read = 1'b0;
        vectors++;
        if (got !== e_data) begin miscompares++; $display("FAIL both_read_data: got %h, required %h", got, e_data); end
        wait_drained();
    endtask

    task automatic test_reset_mid_drain();
        int lat;
        int n;
        int resp_seen;
        int wr_seen;
        int cnt_bad;
        mem_delay = 6;
        do_write(16'h7000, rand_data(), lat);
        do_write(16'h7010, rand_data(), lat);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pmem_write && n < BUDGET);
        @(negedge clk); #1;
        rst_n = 1'b0;
        rst_epoch++;
        exp_q.delete();
        #1;
        vectors += 4;
        if (pmem_write !== 1'b0) begin miscompares++; $display("FAIL rstd_pmem_write: got %b, required 0", pmem_write); end
        if (pmem_read !== 1'b0)  begin miscompares++; $display("FAIL rstd_pmem_read: got %b, required 0", pmem_read); end
        if (count !== '0)        begin miscompares++; $display("FAIL rstd_count: got %0d, required 0", count); end
        if (fsm_state !== EVB_IDLE) begin miscompares++; $display("FAIL rstd_state: got %0d, required %0d", fsm_state, EVB_IDLE); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        resp_seen = 0; wr_seen = 0; cnt_bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (cache_resp) resp_seen++;
            if (pmem_write || pmem_read) wr_seen++;
            if (count != '0) cnt_bad++;
        end
        vectors += 3;
        if (resp_seen != 0) begin miscompares++; $display("FAIL rstd_late_resp: cache_resp seen %0d times, required 0", resp_seen); end
        if (wr_seen != 0)   begin miscompares++; $display("FAIL rstd_pmem_active: pmem access %0d cycles, required 0", wr_seen); end
        if (cnt_bad != 0)   begin miscompares++; $display("FAIL rstd_count_after: nonzero count %0d cycles, required 0", cnt_bad); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat;
        lc3b_word a;
        lc3b_data got, exp;
        mem_delay = -1;
        for (int i = 0; i < 40; i++) begin
            a = 16'h9000 | lc3b_word'($urandom_range(0, 3) << 4);
            if ($urandom_range(0, 2) != 2) begin
                do_write(a, rand_data(), lat);
            end else begin
                exp = coherent(line_of(a));
                do_read(a, got, lat);
                vectors++;
                if (got !== exp) begin miscompares++; $display("FAIL rand_read: addr=%h got %h, required %h", a, got, exp); end
            end
        end
        wait_drained();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single_write();
        test_full_stall();
        test_forward();
        test_read_priority();
        test_read_write_together();
        test_reset_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
